// File: rtl/alarm_sequencer_if.sv
// Alarm sequencer bus: comparator/user inputs toward the sequencer, buzzer/status back.
// master = environment driving match/tick/buttons, slave = the sequencer.
interface alarm_sequencer_if #(
    parameter int unsigned MAX_SNOOZE = 3
);
    localparam int unsigned SNW = $clog2(MAX_SNOOZE + 1);

    logic           tick;
    logic           Alarmon;
    logic           match;
    logic           snooze;
    logic           dismiss;
    logic           Buzz;
    logic           snoozing;
    logic [SNW-1:0] snooze_left;

    modport master (
        output tick, Alarmon, match, snooze, dismiss,
        input  Buzz, snoozing, snooze_left
    );

    modport slave (
        input  tick, Alarmon, match, snooze, dismiss,
        output Buzz, snoozing, snooze_left
    );
endinterface

// File: rtl/alarm_sequencer.sv
// Turns the alarm comparator's match level into a timed ring with snooze/dismiss.
// Optional macro ALARM_SEQ_AUTO_SNOOZE_EN: a ring timeout snoozes instead of going idle.
module alarm_sequencer #(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 540,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic                Pulse,
    input  logic                Reset,
    alarm_sequencer_if.slave    bus
);
    localparam int unsigned RCW = (RING_SECS   > 1) ? $clog2(RING_SECS)   : 1;
    localparam int unsigned SCW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;
    localparam int unsigned SNW = $clog2(MAX_SNOOZE + 1);

    localparam logic [RCW-1:0] RING_LAST   = RCW'(RING_SECS - 1);
    localparam logic [SCW-1:0] SNOOZE_LAST = SCW'(SNOOZE_SECS - 1);
    localparam logic [SNW-1:0] SNOOZE_MAX  = SNW'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [RCW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SCW-1:0] snz_cnt_q, snz_cnt_d;
    logic [SNW-1:0] snooze_left_q, snooze_left_d;
    logic           match_q;
    logic           buzz_q, buzz_d;
    logic           snoozing_q, snoozing_d;

    logic hit_c;
    logic can_snooze_c;
    logic ring_done_c;
    logic snz_done_c;
    logic stop_c;

    // Rising edge of match while enabled starts one alarm event.
    assign hit_c        = bus.Alarmon & bus.match & ~match_q;
    assign can_snooze_c = (snooze_left_q != '0);
    assign ring_done_c  = bus.tick & (ring_cnt_q == RING_LAST);
    assign snz_done_c   = bus.tick & (snz_cnt_q == SNOOZE_LAST);
    assign stop_c       = ~bus.Alarmon | bus.dismiss;

    // Next-state and counter logic; one transition per cycle in priority order.
    always_comb begin
        state_d       = state_q;
        ring_cnt_d    = ring_cnt_q;
        snz_cnt_d     = snz_cnt_q;
        snooze_left_d = snooze_left_q;

        unique case (state_q)
            IDLE: begin
                if (hit_c) begin
                    state_d       = RING;
                    ring_cnt_d    = '0;
                    snooze_left_d = SNOOZE_MAX;
                end
            end

            RING: begin
                if (stop_c) begin
                    state_d = IDLE;
                end else if (bus.snooze && can_snooze_c) begin
                    state_d       = SNOOZE;
                    snz_cnt_d     = '0;
                    snooze_left_d = snooze_left_q - SNW'(1);
                end else if (ring_done_c) begin
`ifdef ALARM_SEQ_AUTO_SNOOZE_EN
                    if (can_snooze_c) begin
                        state_d       = SNOOZE;
                        snz_cnt_d     = '0;
                        snooze_left_d = snooze_left_q - SNW'(1);
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else if (bus.tick) begin
                    ring_cnt_d = ring_cnt_q + RCW'(1);
                end
            end

            SNOOZE: begin
                if (stop_c) begin
                    state_d = IDLE;
                end else if (snz_done_c) begin
                    state_d    = RING;
                    ring_cnt_d = '0;
                end else if (bus.tick) begin
                    snz_cnt_d = snz_cnt_q + SCW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        buzz_d     = (state_d == RING);
        snoozing_d = (state_d == SNOOZE);
    end

    // State register; match_q resets high so a match already present at release never fires.
    always_ff @(posedge Pulse) begin
        if (Reset) begin
            state_q       <= IDLE;
            ring_cnt_q    <= '0;
            snz_cnt_q     <= '0;
            snooze_left_q <= SNOOZE_MAX;
            match_q       <= 1'b1;
            buzz_q        <= 1'b0;
            snoozing_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ring_cnt_q    <= ring_cnt_d;
            snz_cnt_q     <= snz_cnt_d;
            snooze_left_q <= snooze_left_d;
            match_q       <= bus.match;
            buzz_q        <= buzz_d;
            snoozing_q    <= snoozing_d;
        end
    end

    assign bus.Buzz        = buzz_q;
    assign bus.snoozing    = snoozing_q;
    assign bus.snooze_left = snooze_left_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Randomized scoreboard bench for alarm_sequencer against a behavioural alarm model.
module tb_alarm_sequencer;
    localparam int unsigned RING_SECS   = 4;
    localparam int unsigned SNOOZE_SECS = 3;
    localparam int unsigned MAX_SNOOZE  = 2;
    localparam int unsigned SNW         = $clog2(MAX_SNOOZE + 1);
    localparam int          N_CYCLES    = 20000;

    typedef struct packed {
        logic           buzz;
        logic           snoozing;
        logic [SNW-1:0] left;
    } exp_t;

    logic Pulse = 1'b0;
    logic Reset = 1'b1;

    alarm_sequencer_if #(.MAX_SNOOZE(MAX_SNOOZE)) bus ();

    alarm_sequencer #(
        .RING_SECS  (RING_SECS),
        .SNOOZE_SECS(SNOOZE_SECS),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .Pulse(Pulse),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Pulse = ~Pulse;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference alarm: what the user hears, tracked as a phase plus seconds spent in it.
    localparam int QUIET = 0, RINGING = 1, NAPPING = 2;
    int m_phase    = QUIET;
    int m_secs     = 0;
    int m_left     = MAX_SNOOZE;
    bit m_prev_hi  = 1'b1;

    task automatic model_step(input bit rst, input bit tk, input bit on, input bit m,
                              input bit snz, input bit dis);
        bit fresh_minute;
        if (rst) begin
            m_phase   = QUIET;
            m_secs    = 0;
            m_left    = MAX_SNOOZE;
            m_prev_hi = 1'b1;
            return;
        end
        fresh_minute = on && m && !m_prev_hi;
        m_prev_hi    = m;
        if (m_phase == QUIET) begin
            if (fresh_minute) begin
                m_phase = RINGING;
                m_secs  = 0;
                m_left  = MAX_SNOOZE;
            end
        end else if (!on || dis) begin
            m_phase = QUIET;
        end else if (m_phase == RINGING) begin
            if (snz && m_left > 0) begin
                m_phase = NAPPING;
                m_secs  = 0;
                m_left  = m_left - 1;
            end else if (tk) begin
                m_secs = m_secs + 1;
                if (m_secs >= RING_SECS) begin
`ifdef ALARM_SEQ_AUTO_SNOOZE_EN
                    if (m_left > 0) begin
                        m_phase = NAPPING;
                        m_secs  = 0;
                        m_left  = m_left - 1;
                    end else begin
                        m_phase = QUIET;
                    end
`else
                    m_phase = QUIET;
`endif
                end
            end
        end else begin
            if (tk) begin
                m_secs = m_secs + 1;
                if (m_secs >= SNOOZE_SECS) begin
                    m_phase = RINGING;
                    m_secs  = 0;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.buzz     = (m_phase == RINGING);
        e.snoozing = (m_phase == NAPPING);
        e.left     = SNW'(m_left);
        return e;
    endfunction

    task automatic drive(input bit rst, input bit tk, input bit on, input bit m,
                         input bit snz, input bit dis);
        Reset       = rst;
        bus.tick    = tk;
        bus.Alarmon = on;
        bus.match   = m;
        bus.snooze  = snz;
        bus.dismiss = dis;
        model_step(rst, tk, on, m, snz, dis);
        exp_q.push_back(model_out());
    endtask

    // Monitor: every clock the DUT presents a fresh output set, checked against the queue head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Pulse);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (bus.Buzz !== e.buzz) begin
                    n_bad++;
                    $display("FAIL buzz t=%0t got=%b want=%b", $time, bus.Buzz, e.buzz);
                end
                n_cmp++;
                if (bus.snoozing !== e.snoozing) begin
                    n_bad++;
                    $display("FAIL snoozing t=%0t got=%b want=%b", $time, bus.snoozing, e.snoozing);
                end
                n_cmp++;
                if (bus.snooze_left !== e.left) begin
                    n_bad++;
                    $display("FAIL snooze_left t=%0t got=%0d want=%0d", $time, bus.snooze_left, e.left);
                end
            end
        end
    end

    // Driver: minute-like match windows, periodic ticks, sparse button presses and resets.
    initial begin : driver
        int  tick_wait;
        int  match_left;
        bit  match_lvl;
        int  off_left;
        int  rst_left;
        bit  tk, snz, dis, on, rst;
        int  budget;

        bus.tick = 1'b0; bus.Alarmon = 1'b1; bus.match = 1'b1;
        bus.snooze = 1'b0; bus.dismiss = 1'b0;

        // Reset with match already high, then hold match: must never ring.
        for (int i = 0; i < 3; i++) begin
            @(negedge Pulse);
            drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge Pulse);
            drive(1'b0, (i % 3) == 2, 1'b1, 1'b1, 1'b0, 1'b0);
        end

        tick_wait  = 2;
        match_lvl  = 1'b0;
        match_left = 5;
        off_left   = 0;
        rst_left   = 0;
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge Pulse);
            if (match_left == 0) begin
                match_lvl  = !match_lvl;
                match_left = match_lvl ? int'($urandom_range(80, 20)) : int'($urandom_range(30, 3));
            end
            match_left--;

            tk = 1'b0;
            if (tick_wait == 0) begin
                tk        = 1'b1;
                tick_wait = int'($urandom_range(3, 1));
            end else begin
                tick_wait--;
            end

            if (off_left == 0 && $urandom_range(199, 0) == 0) off_left = int'($urandom_range(10, 1));
            on = (off_left == 0);
            if (off_left > 0) off_left--;

            if (rst_left == 0 && $urandom_range(399, 0) == 0) rst_left = int'($urandom_range(3, 1));
            rst = (rst_left > 0);
            if (rst_left > 0) rst_left--;

            snz = ($urandom_range(24, 0) == 0);
            dis = ($urandom_range(119, 0) == 0);
            if (dis && $urandom_range(1, 0) == 1) snz = 1'b1;

            drive(rst, tk, on, match_lvl, snz, dis);
        end

        @(negedge Pulse);
        Reset = 1'b0; bus.tick = 1'b0; bus.snooze = 1'b0; bus.dismiss = 1'b0;
        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge Pulse);
            budget--;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
